// File: rtl/pasta_pkg.sv
// Shared constants and types for the Pasta keystream consumer.
// Words are BITLEN bits wide; values are reduced modulo MODULUS.
package pasta_pkg;

  localparam int PASTA_S = 32;
  localparam int BITLEN  = 17;
  localparam int MODULUS = 65537;
  localparam int IDX_W   = $clog2(PASTA_S);

  // Modulus at the widened arithmetic width (one guard bit above a word).
  localparam logic [BITLEN:0] MOD_EXT = (BITLEN + 1)'(MODULUS);

  typedef logic [BITLEN-1:0] pasta_word_t;
  typedef pasta_word_t pasta_block_t [PASTA_S];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_KS,
    ST_STREAM
  } stream_state_t;

  // Inputs arrive as raw BITLEN-bit words; since 2^BITLEN < 2p, one
  // conditional subtraction is enough to land in [0, p).
  function automatic pasta_word_t pasta_reduce(input pasta_word_t x);
    logic [BITLEN:0] x_ext;
    x_ext = {1'b0, x};
    if (x_ext >= MOD_EXT) begin
      return pasta_word_t'(x_ext - MOD_EXT);
    end
    return x;
  endfunction

endpackage

// File: rtl/pasta_mod_addsub.sv
// Combinational (a + b) mod p or (a - b) mod p on operands already in [0, p).
// One guard bit above the word width keeps the intermediate sum exact.
module pasta_mod_addsub
  import pasta_pkg::*;
(
  input  logic [BITLEN-1:0] a,
  input  logic [BITLEN-1:0] b,
  input  logic              sub,
  output logic [BITLEN-1:0] r
);

  logic [BITLEN:0] a_ext;
  logic [BITLEN:0] b_ext;
  logic [BITLEN:0] sum;
  logic [BITLEN:0] diff;

  always_comb begin
    a_ext = {1'b0, a};
    b_ext = {1'b0, b};
    sum   = a_ext + b_ext;
    diff  = a_ext - b_ext;
    if (sub) begin
      // A borrow wraps diff; adding p brings it back into [1, p-1].
      r = (a_ext < b_ext) ? pasta_word_t'(diff + MOD_EXT) : pasta_word_t'(diff);
    end else begin
      r = (sum >= MOD_EXT) ? pasta_word_t'(sum - MOD_EXT) : pasta_word_t'(sum);
    end
  end

endmodule

// File: rtl/pasta_stream_crypt.sv
// Streams words through (in +/- keystream) mod p, fetching one keystream
// block per 64-bit block counter value from the Pasta permutation wrapper.
module pasta_stream_crypt
  import pasta_pkg::*;
(
  input  logic                        Clk_CI,
  input  logic                        Rst_RI,
  output logic                        KsStart_SO,
  output logic [63:0]                 KsCounter_DO,
  input  logic [PASTA_S*BITLEN-1:0]   KsData_DI,
  input  logic                        KsFinish_SI,
  input  logic [BITLEN-1:0]           In_DI,
  input  logic                        InValid_SI,
  output logic                        InReady_SO,
  input  logic                        InLast_SI,
  input  logic                        Decrypt_SI,
  output logic [BITLEN-1:0]           Out_DO,
  output logic                        OutValid_SO,
  input  logic                        OutReady_SI,
  output logic                        OutLast_SO,
  output logic                        Busy_SO
);

  stream_state_t     state_q, state_d;
  logic              mode_q, mode_d;
  logic [63:0]       counter_q, counter_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  pasta_block_t      buf_q, buf_d;
  logic [BITLEN-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  logic              ks_start;
  logic              in_ready;
  logic              xfer;
  logic              idx_last;
  logic              ks_load;
  logic [BITLEN-1:0] in_red;
  logic [BITLEN-1:0] ks_word;
  logic [BITLEN-1:0] res;

  assign xfer     = InValid_SI && in_ready;
  assign idx_last = (idx_q == IDX_W'(PASTA_S - 1));
  assign ks_load  = (state_q == ST_WAIT_KS) && KsFinish_SI;

  // Keystream buffer: the whole block lands in one cycle, word 0 from the MSBs.
  for (genvar gi = 0; gi < PASTA_S; gi++) begin : g_buf
    assign buf_d[gi] = ks_load ? KsData_DI[(PASTA_S - gi)*BITLEN - 1 -: BITLEN]
                               : buf_q[gi];
  end

  assign in_red  = pasta_reduce(In_DI);
  assign ks_word = buf_q[idx_q];

  pasta_mod_addsub u_addsub (
    .a   (in_red),
    .b   (ks_word),
    .sub (mode_q),
    .r   (res)
  );

  // State register.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin : next_state_comb
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (InValid_SI) state_d = ST_REQ;
      ST_REQ:     state_d = ST_WAIT_KS;
      ST_WAIT_KS: if (KsFinish_SI) state_d = ST_STREAM;
      ST_STREAM: begin
        if (xfer) begin
          if (InLast_SI) begin
            state_d = ST_IDLE;
          end else if (idx_last) begin
            state_d = ST_REQ;
          end
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Moore-style control outputs; the output register may drain while stalled.
  always_comb begin : output_comb
    ks_start = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      ST_REQ:    ks_start = 1'b1;
      ST_STREAM: in_ready = !out_valid_q || OutReady_SI;
      default:   ;
    endcase
  end

  // Datapath and sequencing registers.
  always_comb begin : datapath_comb
    mode_d      = mode_q;
    counter_d   = counter_q;
    idx_d       = idx_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if ((state_q == ST_IDLE) && InValid_SI) begin
      mode_d    = Decrypt_SI;
      counter_d = '0;
    end

    if (ks_load) begin
      idx_d = '0;
    end

    if (xfer) begin
      out_d       = res;
      out_last_d  = InLast_SI;
      out_valid_d = 1'b1;
      if (InLast_SI) begin
        // Rest of the current block is discarded; next message starts afresh.
        counter_d = '0;
        idx_d     = '0;
      end else if (idx_last) begin
        counter_d = counter_q + 64'd1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (OutReady_SI) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      mode_q      <= 1'b0;
      counter_q   <= '0;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < PASTA_S; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      mode_q      <= mode_d;
      counter_q   <= counter_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      buf_q       <= buf_d;
    end
  end

  assign KsStart_SO   = ks_start;
  assign KsCounter_DO = counter_q;
  assign InReady_SO   = in_ready;
  assign Out_DO       = out_q;
  assign OutValid_SO  = out_valid_q;
  assign OutLast_SO   = out_last_q;
  assign Busy_SO      = (state_q != ST_IDLE) || out_valid_q;

endmodule

// File: tb/tb_pasta_stream_crypt.sv
// Directed bench for pasta_stream_crypt with a behavioural keystream
// generator that answers each start pulse after a fixed latency.
module tb_pasta_stream_crypt;
  import pasta_pkg::*;

  localparam int GEN_LAT = 4;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      ks_start;
  logic [63:0]               ks_counter;
  logic [PASTA_S*BITLEN-1:0] ks_data = '0;
  logic                      ks_finish = 1'b0;
  logic [BITLEN-1:0]         in_data = '0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic                      in_last = 1'b0;
  logic                      decrypt = 1'b0;
  logic [BITLEN-1:0]         out_data;
  logic                      out_valid;
  logic                      out_ready = 1'b1;
  logic                      out_last;
  logic                      busy;

  int errors = 0;
  int checks = 0;

  int                ks_sel = 0;
  int                ks_tbl [PASTA_S];
  longint unsigned   ctr_log [$];
  int                in_words [128];
  int                out_log [$];
  bit                last_log [$];

  always #5 clk = ~clk;

  pasta_stream_crypt dut (
    .Clk_CI       (clk),
    .Rst_RI       (rst),
    .KsStart_SO   (ks_start),
    .KsCounter_DO (ks_counter),
    .KsData_DI    (ks_data),
    .KsFinish_SI  (ks_finish),
    .In_DI        (in_data),
    .InValid_SI   (in_valid),
    .InReady_SO   (in_ready),
    .InLast_SI    (in_last),
    .Decrypt_SI   (decrypt),
    .Out_DO       (out_data),
    .OutValid_SO  (out_valid),
    .OutReady_SI  (out_ready),
    .OutLast_SO   (out_last),
    .Busy_SO      (busy)
  );

  function automatic int ks_word(input longint unsigned c, input int i);
    if (ks_sel == 0) return ks_tbl[i];
    return int'(c) * 1000 + i * 7 + 3;
  endfunction

  // Keystream generator model.
  always begin : ks_gen
    longint unsigned c;
    @(negedge clk);
    if (ks_start) begin
      c = ks_counter;
      ctr_log.push_back(c);
      repeat (GEN_LAT) @(negedge clk);
      for (int i = 0; i < PASTA_S; i++) begin
        ks_data[(PASTA_S - i)*BITLEN - 1 -: BITLEN] = BITLEN'(ks_word(c, i));
      end
      ks_finish = 1'b1;
      @(negedge clk);
      ks_finish = 1'b0;
    end
  end

  // Drives one message of n words, toggling Decrypt_SI after the first word
  // and optionally withholding OutReady_SI for stall_len cycles at output stall_at.
  task automatic run_msg(input int n, input bit dec, input int stall_at, input int stall_len);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int stall = 0;
    bit stalling;
    logic [BITLEN-1:0] held = '0;
    out_log.delete();
    last_log.delete();
    while ((sent < n || got < n) && cyc < 3000) begin
      @(negedge clk);
      in_valid = (sent < n);
      in_data  = BITLEN'(in_words[sent]);
      in_last  = (sent == n - 1);
      decrypt  = (sent == 0) ? dec : !dec;
      stalling = (got == stall_at) && out_valid && (stall < stall_len);
      if (stalling) begin
        if (stall == 0) held = out_data;
        stall++;
      end
      out_ready = !stalling;
      #1;
      if (stalling) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: got %b want 0 (stall cycle %0d)", in_ready, stall);
        end
        checks++;
        if (out_data !== held) begin
          errors++;
          $display("FAIL stall_out_stable: got %0d want %0d (stall cycle %0d)", out_data, held, stall);
        end
      end
      if (out_valid && out_ready) begin
        out_log.push_back(int'(out_data));
        last_log.push_back(out_last);
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    if (cyc >= 3000) begin
      checks++;
      errors++;
      $display("FAIL msg_timeout: sent %0d got %0d want %0d", sent, got, n);
    end
    $display("msg n=%0d dec=%0d: %0d words out, %0d cycles", n, dec, got, cyc);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ks_start, in_ready, out_valid, out_last, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", {ks_start, in_ready, out_valid, out_last, busy});
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_out: got %0d want 0", out_data);
    end
    checks++;
    if (ks_counter !== 64'd0) begin
      errors++;
      $display("FAIL reset_counter: got %0d want 0", ks_counter);
    end
  endtask

  task automatic test_encrypt;
    int exp_out [3] = '{11, 22, 4};
    bit exp_last [3] = '{1'b0, 1'b0, 1'b1};
    ks_sel = 0;
    for (int i = 0; i < PASTA_S; i++) ks_tbl[i] = 0;
    ks_tbl[0] = 1; ks_tbl[1] = 2; ks_tbl[2] = 65536;
    in_words[0] = 10; in_words[1] = 20; in_words[2] = 5;
    ctr_log.delete();
    run_msg(3, 1'b0, -1, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_log[k] !== exp_out[k] || last_log[k] !== exp_last[k]) begin
        errors++;
        $display("FAIL enc_word%0d: got %0d last %0d want %0d last %0d",
                 k, out_log[k], last_log[k], exp_out[k], exp_last[k]);
      end
    end
    checks++;
    if (ctr_log.size() != 1 || ctr_log[0] != 0) begin
      errors++;
      $display("FAIL enc_ks_start: got %0d pulses first ctr %0d want 1 pulse ctr 0",
               ctr_log.size(), ctr_log.size() > 0 ? ctr_log[0] : 64'd0);
    end
  endtask

  task automatic test_decrypt;
    int exp_out [3] = '{10, 20, 5};
    in_words[0] = 11; in_words[1] = 22; in_words[2] = 4;
    run_msg(3, 1'b1, -1, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_log[k] !== exp_out[k]) begin
        errors++;
        $display("FAIL dec_word%0d: got %0d want %0d", k, out_log[k], exp_out[k]);
      end
    end
    in_words[0] = 0;
    run_msg(1, 1'b1, -1, 0);
    checks++;
    if (out_log[0] !== 65536 || last_log[0] !== 1'b1) begin
      errors++;
      $display("FAIL dec_borrow: got %0d last %0d want 65536 last 1", out_log[0], last_log[0]);
    end
  endtask

  task automatic test_multiblock;
    int bad = 0;
    int exp;
    ks_sel = 1;
    for (int k = 0; k < 70; k++) in_words[k] = k * 3 + 100;
    ctr_log.delete();
    run_msg(70, 1'b0, -1, 0);
    checks++;
    if (ctr_log.size() != 3) begin
      errors++;
      $display("FAIL mb_pulses: got %0d want 3", ctr_log.size());
    end else begin
      for (int b = 0; b < 3; b++) begin
        checks++;
        if (ctr_log[b] != longint'(b)) begin
          errors++;
          $display("FAIL mb_counter%0d: got %0d want %0d", b, ctr_log[b], b);
        end
      end
    end
    checks++;
    if (out_log[32] !== 1199) begin
      errors++;
      $display("FAIL mb_word32: got %0d want 1199", out_log[32]);
    end
    checks++;
    if (out_log[64] !== 2295) begin
      errors++;
      $display("FAIL mb_word64: got %0d want 2295", out_log[64]);
    end
    for (int k = 0; k < 70; k++) begin
      exp = in_words[k] + (k / 32) * 1000 + (k % 32) * 7 + 3;
      if (out_log[k] !== exp) bad++;
    end
    checks++;
    if (bad != 0 || last_log[69] !== 1'b1 || last_log[68] !== 1'b0) begin
      errors++;
      $display("FAIL mb_all_words: %0d wrong words, last69 %0d last68 %0d want 0 wrong, 1, 0",
               bad, last_log[69], last_log[68]);
    end
    ks_sel = 0;
    ks_tbl[0] = 9;
    in_words[0] = 1;
    ctr_log.delete();
    run_msg(1, 1'b0, -1, 0);
    checks++;
    if (ctr_log.size() != 1 || ctr_log[0] != 0 || out_log[0] !== 10) begin
      errors++;
      $display("FAIL mb_restart: got %0d pulses ctr %0d out %0d want 1 pulse ctr 0 out 10",
               ctr_log.size(), ctr_log.size() > 0 ? ctr_log[0] : 64'd0, out_log[0]);
    end
  endtask

  task automatic test_stall;
    int bad = 0;
    ks_sel = 0;
    for (int i = 0; i < PASTA_S; i++) ks_tbl[i] = i * 11;
    for (int k = 0; k < 10; k++) in_words[k] = k * 5 + 1;
    run_msg(10, 1'b0, 3, 5);
    for (int k = 0; k < 10; k++) if (out_log[k] !== 16 * k + 1) bad++;
    checks++;
    if (bad != 0 || out_log.size() != 10) begin
      errors++;
      $display("FAIL stall_words: %0d wrong of %0d collected want 0 wrong of 10", bad, out_log.size());
    end
  endtask

  task automatic test_reduce;
    ks_sel = 0;
    for (int i = 0; i < PASTA_S; i++) ks_tbl[i] = 0;
    in_words[0] = 65537; in_words[1] = 131071;
    run_msg(2, 1'b0, -1, 0);
    checks++;
    if (out_log[0] !== 0) begin
      errors++;
      $display("FAIL reduce_p: got %0d want 0", out_log[0]);
    end
    checks++;
    if (out_log[1] !== 65534) begin
      errors++;
      $display("FAIL reduce_max: got %0d want 65534", out_log[1]);
    end
  endtask

  task automatic test_reset_mid;
    int cyc = 0;
    ks_sel = 0;
    ks_tbl[0] = 5;
    ctr_log.delete();
    @(negedge clk);
    in_valid = 1'b1; in_data = 17'd7; in_last = 1'b1; decrypt = 1'b0;
    while (!ks_start && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!ks_start) begin
      errors++;
      $display("FAIL rm_start_timeout: got no KsStart_SO want pulse");
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rm_busy_wait: got %b want 1", busy);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (GEN_LAT + 2) @(negedge clk);
    checks++;
    if ({ks_start, in_ready, out_valid, out_last, busy} !== 5'b0 || out_data !== '0 || ks_counter !== 64'd0) begin
      errors++;
      $display("FAIL rm_idle: flags %b out %0d ctr %0d want 00000 0 0",
               {ks_start, in_ready, out_valid, out_last, busy}, out_data, ks_counter);
    end
    checks++;
    if (ctr_log.size() != 1) begin
      errors++;
      $display("FAIL rm_pulses: got %0d want 1", ctr_log.size());
    end
    ctr_log.delete();
    in_words[0] = 7; in_words[1] = 8;
    ks_tbl[1] = 100;
    run_msg(2, 1'b0, -1, 0);
    checks++;
    if (ctr_log.size() != 1 || ctr_log[0] != 0 || out_log[0] !== 12 || out_log[1] !== 108) begin
      errors++;
      $display("FAIL rm_restart: pulses %0d out %0d,%0d want 1 pulse ctr 0 out 12,108",
               ctr_log.size(), out_log[0], out_log[1]);
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_multiblock();
    test_stall();
    test_reduce();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
